// File: rtl/data_unpacker.sv
// Unpacks buffered N-lane trace vectors into chunks of N, M or 1 elements.
// The chunk length is chosen per chain by firmware bytes loaded over the config bus.
module data_unpacker #(
    parameter int N                  = 8,
    parameter int M                  = 2,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE = '0,
    localparam int CW  = $clog2(N) + 1,
    localparam int CHW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tracing,
    input  logic [7:0]              configId,
    input  logic [7:0]              configData,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [N*DATA_WIDTH-1:0] vector_in,
    input  logic [CW-1:0]           count_in,
    input  logic [CHW-1:0]          chainId_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [N*DATA_WIDTH-1:0] vector_out,
    output logic [CW-1:0]           count_out
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = $clog2(MAX_CHAINS + 1);

    logic [DATA_WIDTH-1:0] buf_q [N];
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         remaining;
    logic [CW-1:0]         chunk_len;
    logic [7:0]            firmware [MAX_CHAINS];
    logic [BW-1:0]         byte_counter;

    logic [CW-1:0] cnt_eff;
    logic [7:0]    mode_sel;
    logic          fire_out;
    logic          accept;

    // Handshake: a beat transfers on a rising edge where valid and ready are both
    // high; valid never waits on ready, and an offered chunk holds until taken.
    assign cnt_eff  = (count_in == '0) ? CW'(N) : count_in;
    assign mode_sel = firmware[chainId_in];
    assign fire_out = valid_out & ready_out;
    assign accept   = valid_in & ready_in & tracing;

    always_comb begin
        valid_out  = (remaining != '0);
        count_out  = '0;
        vector_out = '0;
        if (valid_out)
            count_out = (chunk_len < remaining) ? chunk_len : remaining;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) < count_out)
                vector_out[i*DATA_WIDTH +: DATA_WIDTH] = buf_q[IW'(rd_ptr + CW'(i))];
        end
        // The last chunk leaving frees the buffer on the same edge.
        ready_in = (remaining == '0) | (fire_out & (remaining <= chunk_len));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            remaining    <= '0;
            chunk_len    <= CW'(N);
            byte_counter <= '0;
            for (int i = 0; i < N; i++)
                buf_q[i] <= '0;
            for (int k = 0; k < MAX_CHAINS; k++)
                firmware[k] <= INITIAL_FIRMWARE[8*k +: 8];
        end else begin
            if (fire_out) begin
                rd_ptr    <= rd_ptr + count_out;
                remaining <= remaining - count_out;
            end

            // An accept overrides the final drain; mode is frozen with the vector.
            if (accept) begin
                case (mode_sel)
                    8'd0, 8'd1, 8'd2: begin
                        for (int i = 0; i < N; i++)
                            buf_q[i] <= vector_in[i*DATA_WIDTH +: DATA_WIDTH];
                        rd_ptr    <= CW'(N) - cnt_eff;
                        remaining <= cnt_eff;
                        chunk_len <= (mode_sel == 8'd0) ? CW'(N) :
                                     (mode_sel == 8'd1) ? CW'(M) : CW'(1);
                    end
                    default: begin
                        rd_ptr    <= '0;
                        remaining <= '0;
                    end
                endcase
            end

            if (!tracing && (configId == 8'(PERSONAL_CONFIG_ID))) begin
                if (byte_counter < BW'(MAX_CHAINS)) begin
                    firmware[byte_counter[CHW-1:0]] <= configData;
                    byte_counter <= byte_counter + 1'b1;
                end
            end else begin
                byte_counter <= '0;
            end
        end
    end

endmodule

// File: doc/data_unpacker.md
Name: data_unpacker

Overview:
- Inverse of the trace data packer: accepts N-lane packed vectors and re-emits them as chunks of N, M or 1 elements.
- The chunk size is selected per chain by runtime firmware.
- Sits on the readback/replay side of the instrumentation chain, between packed trace storage and the per-element consumers.
- Uses a valid/ready handshake on both sides; one packed vector is buffered.

Parameters:
- N, 8, lanes per packed vector.
- M, 2, mid-size chunk length; 1<=M<=N (need not divide N).
- DATA_WIDTH, 32, bits per lane.
- MAX_CHAINS, 4, number of chains with independent firmware.
- PERSONAL_CONFIG_ID, 0, configId value that addresses this block.
- INITIAL_FIRMWARE, all 0, per-chain 8-bit chunk-mode reset value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- tracing  in  1  1 = run mode; 0 = config mode.
- configId  in  8  config bus target id.
- configData  in  8  config bus byte.
- valid_in  in  1  vector_in valid.
- ready_in  out  1  unpacker can accept vector_in this cycle.
- vector_in  in  DATA_WIDTH x N  packed vector.
- count_in  in  $clog2(N)+1  valid elements in vector_in; they occupy lanes N-count_in..N-1; 0 means N.
- chainId_in  in  $clog2(MAX_CHAINS)  selects firmware entry.
- valid_out  out  1  chunk on vector_out valid.
- ready_out  in  1  downstream accepts chunk.
- vector_out  out  DATA_WIDTH x N  chunk in lanes 0..count_out-1; other lanes 0.
- count_out  out  $clog2(N)+1  elements in current chunk.

Behaviour:
- State: buffer buf[N], rd_ptr, remaining, chunk length L, firmware[MAX_CHAINS], byte_counter.
- Reset (rst_n=0 at posedge):
  - remaining=0, rd_ptr=0, buf cleared, L=N.
  - firmware=INITIAL_FIRMWARE, byte_counter=0.
  - valid_out=0, count_out=0, vector_out all 0.
  - Reset mid-drain discards buffered data.
- Mode decode at acceptance: firmware[chainId_in] 0 -> L=N; 1 -> L=M; 2 -> L=1; other -> drop.
  - Drop: vector is consumed (ready_in honoured), nothing is emitted, remaining stays 0.
- Accept occurs when valid_in & ready_in & tracing.
  - Latch buf=vector_in.
  - Set rd_ptr=N-count_in' (count_in'=N when count_in=0).
  - Set remaining=count_in'.
  - Latch L. Mode is latched per vector; later firmware writes do not affect a buffered vector.
- Outputs are combinational from registers:
  - valid_out = (remaining!=0).
  - count_out = min(L, remaining) when valid, else 0.
  - vector_out[i] = buf[rd_ptr+i] for i<count_out, else 0.
- Latency: a vector accepted at posedge t yields its first chunk valid after t; consecutive chunks follow one per cycle while ready_out=1.
- Drain: when valid_out & ready_out, rd_ptr+=count_out and remaining-=count_out.
  - The final chunk may be shorter than L (remaining<L, or M not dividing N).
- ready_in = (remaining==0) | (valid_out & ready_out & remaining<=L), so a new vector loads on the same edge the last chunk leaves.
  - With L=N and ready_out held high, throughput is 1 vector/cycle.
- Backpressure: ready_out=0 holds vector_out, count_out and valid_out stable.
- Simultaneous last-chunk drain and accept: the accept wins; the buffer reloads with no bubble.
- Output draining continues when tracing=0. Input is accepted only when tracing=1, so ready_in may be 1 while nothing is taken.
- Config: when tracing=0 and configId==PERSONAL_CONFIG_ID, each cycle writes firmware[byte_counter]=configData when byte_counter<MAX_CHAINS, then increments byte_counter.
  - Bytes beyond MAX_CHAINS are ignored.
  - byte_counter resets to 0 whenever configId!=PERSONAL_CONFIG_ID or tracing=1.
- Element order: lowest lane index is the oldest element, matching packer fill order.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with valid_in=1 -> valid_out=0, ready_in=1, count_out=0, vector_out all 0, firmware=INITIAL_FIRMWARE.
- Mode 0 streaming: firmware all 0, ready_out=1, three vectors back-to-back with count_in=0, lanes {0..7},{8..15},{16..23} -> three consecutive cycles with count_out=8 and vectors identical to inputs; ready_in stays 1.
- Mode 1 with M=2: one vector of lanes {10..17} -> four chunks {10,11},{12,13},{14,15},{16,17}; ready_in low for the first 3 chunk cycles; the next vector loads on the 4th chunk's edge with no bubble.
- Mode 2 partial with backpressure: count_in=3, lanes 5..7={A,B,C}, ready_out toggled 1,0,1,1 -> emits A, holds B one cycle, then B, C, each with count_out=1; then valid_out=0.
- Config and drop: tracing=0, configId=0, bytes 2,1,7,0 -> firmware={2,1,7,0}; a vector on chainId 2 is accepted and never produces valid_out; a vector on chainId 0 emits 1-element chunks.
- Reset mid-drain: mode 2, rst_n=0 after 2 chunks -> next cycle valid_out=0 and remaining data is not emitted after reset release.
